muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             ready,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_bits,
    output logic [WIDTH-1:0] lo_bits
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic is_neg);
        return is_neg ? neg_w(v) : v;
    endfunction

    // Control state (reset)
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Datapath state (no reset; always loaded on an accepted start)
    logic [1:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Mul: work_hi holds the running upper product, work_lo the shifting multiplier.
    // Div: work_hi holds the partial remainder, work_lo the dividend shifting into quotient.
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? mcand_q : '0)};
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        prod      = {work_hi_q, work_lo_q};
        if (a_neg_q ^ b_neg_q) begin
            prod = neg_2w(prod);
        end
        quo = (a_neg_q ^ b_neg_q) ? neg_w(work_lo_q) : work_lo_q;
        rem = a_neg_q ? neg_w(work_hi_q) : work_hi_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        opa_d     = opa_q;
        mcand_d   = mcand_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    a_neg_d   = op[0] & opA[WIDTH-1];
                    b_neg_d   = op[0] & opB[WIDTH-1];
                    b_zero_d  = (opB == '0);
                    opa_d     = opA;
                    mcand_d   = mag_w(opB, op[0] & opB[WIDTH-1]);
                    work_hi_d = '0;
                    work_lo_d = mag_w(opA, op[0] & opA[WIDTH-1]);
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (!op_q[1]) begin
                    work_hi_d = mul_sum[WIDTH:1];
                    work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                end else begin
                    work_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                div0_d  = op_q[1] & b_zero_q;
                state_d = S_IDLE;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        a_neg_q   <= a_neg_d;
        b_neg_q   <= b_neg_d;
        b_zero_q  <= b_zero_d;
        opa_q     <= opa_d;
        mcand_q   <= mcand_d;
        work_hi_q <= work_hi_d;
        work_lo_q <= work_lo_d;
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = done_q;
    assign div0    = div0_q;
    assign hi_bits = hi_q;
    assign lo_bits = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with per-cycle compare,
// plus directed operations with hand-computed results and latencies.
module tb_muldiv_unit;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opA, opB;
    logic         ready, done, div0;
    logic [W-1:0] hi_bits, lo_bits;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .ready(ready), .done(done), .div0(div0), .hi_bits(hi_bits), .lo_bits(lo_bits)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ecnt  = 0;
    bit armed = 1'b0;

    bit           m_busy = 1'b0;
    int           m_due  = 0;
    logic         m_done = 1'b0, m_div0 = 1'b0, p_div0 = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    task automatic model_calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
        logic [2*W-1:0]     pu;
        logic signed [63:0] ps;
        logic signed [31:0] sa, sb, sq, sr;
        rd = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin
                pu = (2*W)'(a) * (2*W)'(b);
                rh = pu[2*W-1:W];
                rl = pu[W-1:0];
            end
            2'd1: begin
                ps = sa * sb;
                rh = ps[2*W-1:W];
                rl = ps[W-1:0];
            end
            default: begin
                if (b == '0) begin
                    rh = a;
                    rl = '1;
                    rd = 1'b1;
                end else if (o == 2'd2) begin
                    rl = a / b;
                    rh = a % b;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    rl = sq[W-1:0];
                    rh = sr[W-1:0];
                end
            end
        endcase
    endtask

    // Reference model: fixed latency, ignore start while busy, reset kills pending op
    always @(posedge clk) begin
        ecnt++;
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_div0 = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (ecnt == m_due) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_div0 = p_div0;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_due  = ecnt + LAT;
                model_calc(op, opA, opB, p_hi, p_lo, p_div0);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            n_vec++;
            if ({ready, done, div0, hi_bits, lo_bits} !== {!m_busy, m_done, m_div0, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL cycle%0d: got rdy=%b done=%b div0=%b hi=%h lo=%h, want rdy=%b done=%b div0=%b hi=%h lo=%h",
                         ecnt, ready, done, div0, hi_bits, lo_bits, !m_busy, m_done, m_div0, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
        op = o; opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = ecnt;
        op = ~o; opA = ~a; opB = b ^ 16'h5A5A;
    endtask

    task automatic wait_done(input string nm, output bit found);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done, want done within 40 cycles", nm);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int t0;
        bit found;
        issue(o, a, b, t0);
        wait_done(nm, found);
        if (found) begin
            chk({nm, "_lat"}, ecnt - t0, LAT);
            chk({nm, "_hi"}, 32'(hi_bits), 32'(eh));
            chk({nm, "_lo"}, 32'(lo_bits), 32'(el));
            chk({nm, "_div0"}, 32'(div0), 32'(ed));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int  t0;
        int  ndone;
        bit  found;
        reset = 1'b1; start = 1'b0; op = 2'd0; opA = '0; opB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_div0", 32'(div0), 0);
        chk("rst_hi", 32'(hi_bits), 0);
        chk("rst_lo", 32'(lo_bits), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Each run_op starts in the done cycle of the previous one
        run_op("mulu_max",  2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        run_op("muls_neg",  2'd1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0);
        run_op("mulu_b2b",  2'd0, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 1'b0);
        run_op("divu",      2'd2, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0);
        run_op("divs_nd",   2'd3, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
        run_op("divs_ovf",  2'd3, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
        run_op("divu_zero", 2'd2, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
        run_op("mulu_one",  2'd0, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1'b0);
        run_op("muls_min",  2'd1, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
        run_op("divs_pn",   2'd3, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0);
        run_op("divs_nn",   2'd3, 16'hFFF9, 16'hFFFE, 16'hFFFF, 16'h0003, 1'b0);
        run_op("divs_zero", 2'd3, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1);
        run_op("muls_mix",  2'd1, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000, 1'b0);

        // Start while busy must be ignored
        issue(2'd0, 16'h0003, 16'h0004, t0);
        repeat (5) @(posedge clk);
        #1;
        op = 2'd1; opA = 16'h0007; opB = 16'h0009; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ign", found);
        if (found) begin
            chk("busy_ign_lat", ecnt - t0, LAT);
            chk("busy_ign_lo", 32'(lo_bits), 32'h000C);
            chk("busy_ign_hi", 32'(hi_bits), 32'h0000);
        end
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_ign_extra_done", ndone, 0);

        // Reset in the middle of a divide
        issue(2'd2, 16'h1234, 16'h0007, t0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_ready", 32'(ready), 1);
        chk("abort_done", 32'(done), 0);
        chk("abort_hi", 32'(hi_bits), 0);
        chk("abort_lo", 32'(lo_bits), 0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Reset and start together: start is dropped
        op = 2'd0; opA = 16'h0005; opB = 16'h0005; start = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; reset = 1'b0;
        chk("rst_start_ready", 32'(ready), 1);

        run_op("mulu_last", 2'd0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
